// File: rtl/strv32i_pkg.sv
// Shared RV32I constants: major opcodes, ALU opcode encodings and funct7 values
// used by the decode stage and the ALU it feeds.
package strv32i_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // ALU opcodes are {funct7[5], funct3}
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_op_decoder_imm_gen.sv
// Immediate extraction for the decode stage; only the upper instruction bits
// carry immediates for the formats handled here, so only those are taken in.
module imm_gen (
    input  logic [31:12] instr,
    output logic [31:0]  imm_i,
    output logic [31:0]  imm_shamt,
    output logic [31:0]  imm_u
);

    assign imm_i     = {{20{instr[31]}}, instr[31:20]};
    assign imm_shamt = {27'b0, instr[24:20]};
    assign imm_u     = {instr[31:12], 12'b0};

endmodule

// File: rtl/alu_op_decoder.sv
// Registered RV32I decode stage: selects ALU opcode and operands, one output
// register with valid/ready handshake, flush and a wrapping transfer counter.
module alu_op_decoder
    import strv32i_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic                   flush_in,
    input  logic                   instr_valid_in,
    output logic                   instr_ready_out,
    input  logic [31:0]            instr_in,
    input  logic [XLEN-1:0]        pc_in,
    input  logic [XLEN-1:0]        rs1_data_in,
    input  logic [XLEN-1:0]        rs2_data_in,
    output logic                   alu_valid_out,
    input  logic                   alu_ready_in,
    output logic [3:0]             opcode_out,
    output logic signed [XLEN-1:0] op_1_out,
    output logic signed [XLEN-1:0] op_2_out,
    output logic [4:0]             rd_out,
    output logic                   rd_wr_en_out,
    output logic                   illegal_out,
    output logic [CNT_W-1:0]       xfer_count_out
);

    // Handshake: a transfer happens on a side whenever its valid and ready are
    // both high at a rising edge; the held output only moves on such a transfer.

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rd;
    logic [31:0]     imm_i;
    logic [31:0]     imm_shamt;
    logic [31:0]     imm_u;
    logic            legal;
    logic [3:0]      d_opcode;
    logic [XLEN-1:0] d_op1;
    logic [XLEN-1:0] d_op2;
    logic            d_wr_en;
    logic            in_xfer;
    logic            out_xfer;

    assign opc = instr_in[6:0];
    assign rd  = instr_in[11:7];
    assign f3  = instr_in[14:12];
    assign f7  = instr_in[31:25];

    imm_gen u_imm_gen (
        .instr     (instr_in[31:12]),
        .imm_i     (imm_i),
        .imm_shamt (imm_shamt),
        .imm_u     (imm_u)
    );

    always_comb begin
        legal    = 1'b0;
        d_opcode = ALU_ADD;
        d_op1    = '0;
        d_op2    = '0;
        case (opc)
            OPC_OP: begin
                legal    = (f7 == F7_BASE) ||
                           ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
                d_opcode = {instr_in[30], f3};
                d_op1    = rs1_data_in;
                d_op2    = rs2_data_in;
            end
            OPC_OP_IMM: begin
                d_op1 = rs1_data_in;
                if (f3 == 3'b001) begin
                    legal    = (f7 == F7_BASE);
                    d_opcode = {instr_in[30], f3};
                    d_op2    = imm_shamt;
                end else if (f3 == 3'b101) begin
                    legal    = (f7 == F7_BASE) || (f7 == F7_ALT);
                    d_opcode = {instr_in[30], f3};
                    d_op2    = imm_shamt;
                end else begin
                    legal    = 1'b1;
                    d_opcode = {1'b0, f3};
                    d_op2    = imm_i;
                end
            end
            OPC_LUI: begin
                legal = 1'b1;
                d_op2 = imm_u;
            end
            OPC_AUIPC: begin
                legal = 1'b1;
                d_op1 = pc_in;
                d_op2 = imm_u;
            end
            default: ;
        endcase
        // Unsupported encodings travel as an inert ADD of zeros
        if (!legal) begin
            d_opcode = ALU_ADD;
            d_op1    = '0;
            d_op2    = '0;
        end
    end

    assign d_wr_en         = legal && (rd != 5'd0);
    assign instr_ready_out = !alu_valid_out || alu_ready_in;
    assign in_xfer         = instr_valid_in && instr_ready_out;
    assign out_xfer        = alu_valid_out && alu_ready_in;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            alu_valid_out  <= 1'b0;
            opcode_out     <= '0;
            op_1_out       <= '0;
            op_2_out       <= '0;
            rd_out         <= '0;
            rd_wr_en_out   <= 1'b0;
            illegal_out    <= 1'b0;
            xfer_count_out <= '0;
        end else begin
            if (out_xfer) begin
                xfer_count_out <= xfer_count_out + CNT_W'(1);
            end
            // Flush drops both the held output and anything accepted this cycle
            if (flush_in) begin
                alu_valid_out <= 1'b0;
            end else if (in_xfer) begin
                alu_valid_out <= 1'b1;
                opcode_out    <= d_opcode;
                op_1_out      <= d_op1;
                op_2_out      <= d_op2;
                rd_out        <= rd;
                rd_wr_en_out  <= d_wr_en;
                illegal_out   <= !legal;
            end else if (out_xfer) begin
                alu_valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_decoder.sv
// Bench for alu_op_decoder: directed vector table, handshake corner sequences
// and randomized traffic against a cycle-level reference model.
module tb_alu_op_decoder;

    localparam int CNT_W = 16;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        wr_en;
        logic        illegal;
    } dec_t;

    localparam int DW = $bits(dec_t);

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        dec_t        exp;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset_in = 1'b0;
    logic               flush_in = 1'b0;
    logic               instr_valid_in = 1'b0;
    logic               instr_ready_out;
    logic [31:0]        instr_in = '0;
    logic [31:0]        pc_in = '0;
    logic [31:0]        rs1_data_in = '0;
    logic [31:0]        rs2_data_in = '0;
    logic               alu_valid_out;
    logic               alu_ready_in = 1'b0;
    logic [3:0]         opcode_out;
    logic signed [31:0] op_1_out;
    logic signed [31:0] op_2_out;
    logic [4:0]         rd_out;
    logic               rd_wr_en_out;
    logic               illegal_out;
    logic [CNT_W-1:0]   xfer_count_out;

    int n_checks = 0;
    int n_fail   = 0;
    int m_count  = 0;
    logic [DW-1:0] exp_q[$];
    vec_t vecs[11];

    alu_op_decoder #(.XLEN(32), .CNT_W(CNT_W)) dut (
        .clk_in          (clk),
        .reset_in        (reset_in),
        .flush_in        (flush_in),
        .instr_valid_in  (instr_valid_in),
        .instr_ready_out (instr_ready_out),
        .instr_in        (instr_in),
        .pc_in           (pc_in),
        .rs1_data_in     (rs1_data_in),
        .rs2_data_in     (rs2_data_in),
        .alu_valid_out   (alu_valid_out),
        .alu_ready_in    (alu_ready_in),
        .opcode_out      (opcode_out),
        .op_1_out        (op_1_out),
        .op_2_out        (op_2_out),
        .rd_out          (rd_out),
        .rd_wr_en_out    (rd_wr_en_out),
        .illegal_out     (illegal_out),
        .xfer_count_out  (xfer_count_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode written from the instruction-set rules directly
    function automatic dec_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] a, input logic [31:0] b);
        dec_t r;
        int   f3, f7, opc, alt;
        bit   legal;
        f3    = int'(ins[14:12]);
        f7    = int'(ins[31:25]);
        opc   = int'(ins[6:0]);
        alt   = (f7 == 32) ? 8 : 0;
        r     = '0;
        r.rd  = ins[11:7];
        legal = 1'b0;
        if (opc == 'h33) begin
            legal    = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
            r.opcode = 4'(f3 + alt);
            r.op1    = a;
            r.op2    = b;
        end else if (opc == 'h13) begin
            r.op1 = a;
            if (f3 == 1 || f3 == 5) begin
                legal    = (f7 == 0) || (f3 == 5 && f7 == 32);
                r.opcode = 4'(f3 + alt);
                r.op2    = 32'(ins[24:20]);
            end else begin
                legal    = 1'b1;
                r.opcode = 4'(f3);
                r.op2    = 32'($signed(ins[31:20]));
            end
        end else if (opc == 'h37 || opc == 'h17) begin
            legal    = 1'b1;
            r.opcode = 4'd0;
            r.op1    = (opc == 'h17) ? pc : 32'd0;
            r.op2    = ins & 32'hFFFF_F000;
        end
        if (!legal) begin
            r.opcode = 4'd0;
            r.op1    = 32'd0;
            r.op2    = 32'd0;
        end
        r.illegal = !legal;
        r.wr_en   = legal && (r.rd != 5'd0);
        return r;
    endfunction

    function automatic dec_t dut_fields();
        dec_t r;
        r.opcode  = opcode_out;
        r.op1     = op_1_out;
        r.op2     = op_2_out;
        r.rd      = rd_out;
        r.wr_en   = rd_wr_en_out;
        r.illegal = illegal_out;
        return r;
    endfunction

    function automatic vec_t mkv(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] op, input logic [31:0] o1,
                                 input logic [31:0] o2, input logic [4:0] rd,
                                 input logic we, input logic ill);
        vec_t v;
        v.instr       = ins;
        v.pc          = pc;
        v.rs1         = a;
        v.rs2         = b;
        v.exp.opcode  = op;
        v.exp.op1     = o1;
        v.exp.op2     = o2;
        v.exp.rd      = rd;
        v.exp.wr_en   = we;
        v.exp.illegal = ill;
        return v;
    endfunction

    // One clock: predict from the current inputs, advance, compare against the model
    task automatic step();
        bit   m_valid, acc, oxf;
        dec_t nxt;
        #1;
        m_valid = (exp_q.size() != 0);
        check("ready", instr_ready_out, !m_valid || alu_ready_in);
        acc = instr_valid_in && (!m_valid || alu_ready_in) && !flush_in && !reset_in;
        oxf = m_valid && alu_ready_in && !reset_in;
        nxt = ref_decode(instr_in, pc_in, rs1_data_in, rs2_data_in);
        @(posedge clk);
        #1;
        if (reset_in) begin
            exp_q.delete();
            m_count = 0;
        end else begin
            if (oxf) begin
                void'(exp_q.pop_front());
                m_count = (m_count + 1) % (1 << CNT_W);
            end
            if (flush_in) exp_q.delete();
            if (acc) exp_q.push_back(nxt);
        end
        check("valid", alu_valid_out, exp_q.size() != 0);
        check("count", xfer_count_out, m_count);
        if (exp_q.size() != 0) check("fields", dut_fields(), exp_q[0]);
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b);
        instr_in    = ins;
        pc_in       = pc;
        rs1_data_in = a;
        rs2_data_in = b;
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        step();
        step();
        reset_in = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  opcs[5];
        logic [6:0]  f7s[3];
        opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03};
        f7s  = '{7'h00, 7'h20, 7'h7F};
        w = $urandom();
        w[6:0] = opcs[$urandom_range(0, 4)];
        if ($urandom_range(0, 7) != 0) w[31:25] = f7s[$urandom_range(0, 2)];
        if ($urandom_range(0, 9) == 0) w[6:0] = 7'($urandom());
        return w;
    endfunction

    initial begin
        vecs[0]  = mkv(32'h402081B3, 32'h0,   32'd10,        32'd3, 4'h8, 32'd10,        32'd3,         5'd3, 1'b1, 1'b0);
        vecs[1]  = mkv(32'hFFF00293, 32'h0,   32'd0,         32'd0, 4'h0, 32'd0,         32'hFFFF_FFFF, 5'd5, 1'b1, 1'b0);
        vecs[2]  = mkv(32'h40435313, 32'h0,   32'h8000_0000, 32'd0, 4'hD, 32'h8000_0000, 32'd4,         5'd6, 1'b1, 1'b0);
        vecs[3]  = mkv(32'h12345397, 32'h100, 32'hDEAD,      32'd1, 4'h0, 32'h100,       32'h1234_5000, 5'd7, 1'b1, 1'b0);
        vecs[4]  = mkv(32'h00001037, 32'h40,  32'd9,         32'd9, 4'h0, 32'd0,         32'h1000,      5'd0, 1'b0, 1'b0);
        vecs[5]  = mkv(32'h4020F1B3, 32'h0,   32'd5,         32'd6, 4'h0, 32'd0,         32'd0,         5'd3, 1'b0, 1'b1);
        vecs[6]  = mkv(32'h003100B3, 32'h0,   32'd7,         32'd9, 4'h0, 32'd7,         32'd9,         5'd1, 1'b1, 1'b0);
        vecs[7]  = mkv(32'h40009093, 32'h0,   32'd7,         32'd9, 4'h0, 32'd0,         32'd0,         5'd1, 1'b0, 1'b1);
        vecs[8]  = mkv(32'h00002083, 32'h0,   32'd7,         32'd9, 4'h0, 32'd0,         32'd0,         5'd1, 1'b0, 1'b1);
        vecs[9]  = mkv(32'hFFB12213, 32'h0,   32'd2,         32'd9, 4'h2, 32'd2,         32'hFFFF_FFFB, 5'd4, 1'b1, 1'b0);
        vecs[10] = mkv(32'h4020D1B3, 32'h0,   32'hF0,        32'd4, 4'hD, 32'hF0,        32'd4,         5'd3, 1'b1, 1'b0);

        // Reset
        do_reset();
        check("reset_valid", alu_valid_out, 1'b0);
        check("reset_fields", dut_fields(), '0);
        check("reset_count", xfer_count_out, '0);
        check("reset_ready", instr_ready_out, 1'b1);

        // Directed vector table, one instruction at a time, ready held high
        alu_ready_in = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
            instr_valid_in = 1'b1;
            step();
            instr_valid_in = 1'b0;
            check($sformatf("vec%0d", i), dut_fields(), vecs[i].exp);
            step();
        end
        check("vec_count", xfer_count_out, 16'd11);

        // Stall: output held for three cycles with ready low
        drive(vecs[0].instr, 32'h0, 32'd10, 32'd3);
        instr_valid_in = 1'b1;
        step();
        drive(vecs[6].instr, 32'h0, 32'd1, 32'd2);
        alu_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_ready", instr_ready_out, 1'b0);
            check("stall_fields", dut_fields(), vecs[0].exp);
        end
        alu_ready_in = 1'b1;
        instr_valid_in = 1'b0;
        step();
        step();

        // Back-to-back stream of four
        begin
            int run = 0;
            instr_valid_in = 1'b1;
            for (int i = 0; i < 4; i++) begin
                drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
                step();
                if (alu_valid_out === 1'b1) run++;
            end
            instr_valid_in = 1'b0;
            check("b2b_run", run, 4);
            step();
        end

        // Flush with a new input in the same cycle
        drive(vecs[2].instr, 32'h0, 32'd1, 32'd0);
        instr_valid_in = 1'b1;
        step();
        drive(vecs[3].instr, 32'h100, 32'd0, 32'd0);
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        instr_valid_in = 1'b0;
        check("flush_valid", alu_valid_out, 1'b0);
        step();
        check("flush_lost", alu_valid_out, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            drive(rand_instr(), $urandom(), $urandom(), $urandom());
            instr_valid_in = ($urandom_range(0, 3) != 0);
            alu_ready_in   = ($urandom_range(0, 3) != 0);
            flush_in       = ($urandom_range(0, 24) == 0);
            reset_in       = ($urandom_range(0, 299) == 0);
            step();
        end
        flush_in = 1'b0;
        reset_in = 1'b0;

        // Counter wrap after 0xFFFF transfers
        do_reset();
        alu_ready_in   = 1'b1;
        instr_valid_in = 1'b1;
        drive(vecs[6].instr, 32'h0, 32'd1, 32'd2);
        for (int i = 0; i < 70000 && m_count != 32'hFFFF; i++) step();
        check("wrap_pre", xfer_count_out, 16'hFFFF);
        step();
        check("wrap_zero", xfer_count_out, 16'h0000);
        instr_valid_in = 1'b0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
